ysyx_23060203_ifu: RTL and testbench

Instruction fetch unit for the ysyx_23060203 core, feeding the decode stage. Holds the architectural PC and issues one instruction-memory read at a time over an AXI-lite style AR/R channel pair. Presents the returned word to decode over a valid/ready handshake. Accepts PC redirects (jumps/branches) from the execute stage and discards any fetch that is in flight when a redirect arrives.

---
 rtl/ysyx_23060203_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_23060203_ifu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_ifu.sv
// ysyx_23060203_ifu: instruction fetch unit, one outstanding AR/R read, valid/ready to decode,
// redirects from execute discard any fetch already in flight.
`default_nettype none

module ysyx_23060203_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        mem_arvalid,
   output logic [31:0] mem_araddr,
   input  logic        mem_arready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        mem_rready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic        inst_ready,
   input  logic        jmp_valid,
   input  logic [31:0] jmp_addr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   logic [1:0]  state_q,    state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] inst_q,     inst_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] next_pc_q,  next_pc_d;
   logic        flush_q,    flush_d;
   logic [31:0] jmp_tgt;

   assign jmp_tgt = {jmp_addr[31:2], 2'b00};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      inst_d     = inst_q;
      pc_d       = pc_q;
      next_pc_d  = next_pc_q;
      flush_d    = flush_q;
      case (state_q)
         S_IDLE: begin
            if (jmp_valid) fetch_pc_d = jmp_tgt;
            state_d = S_REQ;
         end
         S_REQ: begin
            // The address must stay stable on AR, so a redirect here only arms the flush.
            if (jmp_valid) begin
               flush_d   = 1'b1;
               next_pc_d = jmp_tgt;
            end
            if (mem_arready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               if (jmp_valid) begin
                  flush_d    = 1'b0;
                  fetch_pc_d = jmp_tgt;
                  state_d    = S_REQ;
               end else if (flush_q) begin
                  flush_d    = 1'b0;
                  fetch_pc_d = next_pc_q;
                  state_d    = S_REQ;
               end else begin
                  inst_d  = mem_rdata;
                  pc_d    = fetch_pc_q;
                  state_d = S_OUT;
               end
            end else if (jmp_valid) begin
               flush_d   = 1'b1;
               next_pc_d = jmp_tgt;
            end
         end
         default: begin
            // A redirect overrides the sequential +4 even when decode accepts this cycle.
            if (jmp_valid) begin
               fetch_pc_d = jmp_tgt;
               state_d    = S_REQ;
            end else if (inst_ready) begin
               fetch_pc_d = pc_q + 32'd4;
               state_d    = S_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         inst_q     <= 32'd0;
         pc_q       <= 32'd0;
         next_pc_q  <= 32'd0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         inst_q     <= inst_d;
         pc_q       <= pc_d;
         next_pc_q  <= next_pc_d;
         flush_q    <= flush_d;
      end
   end

   assign mem_arvalid = (state_q == S_REQ);
   assign mem_araddr  = fetch_pc_q;
   assign mem_rready  = (state_q == S_WAIT);
   assign inst_valid  = (state_q == S_OUT);
   assign inst        = inst_q;
   assign pc          = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060203_ifu.sv
// Testbench for ysyx_23060203_ifu: cycle-level vector table plus multi-cycle memory sequences.
`default_nettype none

module tb_ysyx_23060203_ifu;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        mem_arvalid, mem_rready, inst_valid;
   logic [31:0] mem_araddr, inst, pc;
   logic        mem_arready = 1'b0, mem_rvalid = 1'b0, inst_ready = 1'b0, jmp_valid = 1'b0;
   logic [31:0] mem_rdata = 32'd0, jmp_addr = 32'd0;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ysyx_23060203_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rstn(rstn),
      .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
      .inst_valid(inst_valid), .inst(inst), .pc(pc), .inst_ready(inst_ready),
      .jmp_valid(jmp_valid), .jmp_addr(jmp_addr)
   );

   typedef struct {
      logic        ar, rv;
      logic [31:0] rdata;
      logic        ir, jv;
      logic [31:0] jaddr;
      logic        eav;
      logic [31:0] eaa;
      logic        err, eiv;
      logic [31:0] einst, epc;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic v(input logic ar, input logic rv, input logic [31:0] rdata, input logic ir,
                    input logic jv, input logic [31:0] jaddr, input logic eav, input logic [31:0] eaa,
                    input logic err, input logic eiv, input logic [31:0] einst, input logic [31:0] epc);
      vec_t e;
      e.ar = ar; e.rv = rv; e.rdata = rdata; e.ir = ir; e.jv = jv; e.jaddr = jaddr;
      e.eav = eav; e.eaa = eaa; e.err = err; e.eiv = eiv; e.einst = einst; e.epc = epc;
      vq.push_back(e);
   endtask

   task automatic idle_inputs();
      mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      inst_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = 32'd0;
   endtask

   task automatic do_reset(input bit chk);
      idle_inputs();
      rstn = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (chk)
            check("reset_outputs", {mem_arvalid, mem_rready, inst_valid, inst, pc},
                  {1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
      end
      rstn = 1'b1;
   endtask

   // Entry and exit on a falling edge; ard/rd are AR and R stall cycles.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int ard, input int rd);
      int n = 0;
      while (!mem_arvalid && n < 20) begin @(negedge clk); n++; end
      check("fetch_arvalid", {127'd0, mem_arvalid}, 128'd1);
      check("fetch_araddr", {96'd0, mem_araddr}, {96'd0, addr});
      for (int k = 0; k < ard; k++) begin
         @(negedge clk);
         check("ar_hold", {mem_arvalid, mem_araddr}, {1'b1, addr});
      end
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      check("fetch_rready", {127'd0, mem_rready}, 128'd1);
      for (int k = 0; k < rd; k++) begin
         @(negedge clk);
         check("r_wait", {mem_rready, inst_valid}, {1'b1, 1'b0});
      end
      mem_rvalid = 1'b1; mem_rdata = data;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("fetch_out", {inst_valid, inst, pc}, {1'b1, data, addr});
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   initial begin
      //  ar rv rdata         ir jv jaddr           av araddr        rr iv inst          pc
      v(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h80000000, 0, 0, 32'h0,        32'h0);
      v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000000, 0, 0, 32'h0,        32'h0);
      v(0, 1, 32'h00000413, 0, 0, 32'h0,        0, 32'h80000000, 1, 0, 32'h0,        32'h0);
      for (int i = 0; i < 4; i++)
         v(0, 0, 32'h0,     0, 0, 32'h0,        0, 32'h80000000, 0, 1, 32'h00000413, 32'h80000000);
      v(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h80000000, 0, 1, 32'h00000413, 32'h80000000);
      v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000004, 0, 0, 32'h00000413, 32'h80000000);
      v(0, 1, 32'h00100093, 0, 0, 32'h0,        0, 32'h80000004, 1, 0, 32'h00000413, 32'h80000000);
      v(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h80000004, 0, 1, 32'h00100093, 32'h80000004);
      v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000008, 0, 0, 32'h00100093, 32'h80000004);
      v(0, 0, 32'h0,        0, 1, 32'h80000103, 0, 32'h80000008, 1, 0, 32'h00100093, 32'h80000004);
      v(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h80000008, 1, 0, 32'h00100093, 32'h80000004);
      v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000100, 0, 0, 32'h00100093, 32'h80000004);
      v(0, 1, 32'h00200113, 0, 0, 32'h0,        0, 32'h80000100, 1, 0, 32'h00100093, 32'h80000004);
      v(0, 0, 32'h0,        1, 1, 32'h80000200, 0, 32'h80000100, 0, 1, 32'h00200113, 32'h80000100);
      v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000200, 0, 0, 32'h00200113, 32'h80000100);
      v(0, 1, 32'h11111111, 0, 1, 32'h80000300, 0, 32'h80000200, 1, 0, 32'h00200113, 32'h80000100);
      v(1, 0, 32'h0,        0, 1, 32'h80000404, 1, 32'h80000300, 0, 0, 32'h00200113, 32'h80000100);
      v(0, 1, 32'h22222222, 0, 0, 32'h0,        0, 32'h80000300, 1, 0, 32'h00200113, 32'h80000100);
      v(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000404, 0, 0, 32'h00200113, 32'h80000100);
      v(0, 1, 32'h00300193, 0, 0, 32'h0,        0, 32'h80000404, 1, 0, 32'h00200113, 32'h80000100);
      v(0, 1, 32'h33333333, 0, 0, 32'h0,        0, 32'h80000404, 0, 1, 32'h00300193, 32'h80000404);
      v(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h80000404, 0, 1, 32'h00300193, 32'h80000404);
      v(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000408, 0, 0, 32'h00300193, 32'h80000404);

      @(negedge clk);
      do_reset(1'b1);
      foreach (vq[i]) begin
         mem_arready = vq[i].ar; mem_rvalid = vq[i].rv; mem_rdata = vq[i].rdata;
         inst_ready = vq[i].ir; jmp_valid = vq[i].jv; jmp_addr = vq[i].jaddr;
         check($sformatf("vec%0d", i), {mem_arvalid, mem_araddr, mem_rready, inst_valid, inst, pc},
               {vq[i].eav, vq[i].eaa, vq[i].err, vq[i].eiv, vq[i].einst, vq[i].epc});
         @(negedge clk);
      end
      idle_inputs();

      // Sequential stream of 8 instructions.
      do_reset(1'b0);
      for (int i = 0; i < 8; i++)
         do_fetch(32'h80000000 + 32'(4 * i), 32'h00000013 + 32'(i << 7), i % 2, i % 3);

      // Slow memory with a redirect during the AR stall.
      do_reset(1'b0);
      for (int n = 0; n < 20 && !mem_arvalid; n++) @(negedge clk);
      check("slow_araddr", {mem_arvalid, mem_araddr}, {1'b1, 32'h80000000});
      jmp_valid = 1'b1; jmp_addr = 32'h80000040;
      @(negedge clk);
      jmp_valid = 1'b0; jmp_addr = 32'h0;
      for (int k = 0; k < 2; k++) begin
         check("slow_ar_hold", {mem_arvalid, mem_araddr}, {1'b1, 32'h80000000});
         @(negedge clk);
      end
      check("slow_ar_hold", {mem_arvalid, mem_araddr}, {1'b1, 32'h80000000});
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("slow_r_wait", {mem_rready, inst_valid}, {1'b1, 1'b0});
         @(negedge clk);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("stale_dropped", {inst_valid, mem_arvalid, mem_araddr}, {1'b0, 1'b1, 32'h80000040});
      do_fetch(32'h80000040, 32'h00a00513, 3, 5);
      do_fetch(32'h80000044, 32'h00b00593, 0, 0);

      // Asynchronous reset while waiting for read data.
      do_reset(1'b0);
      do_fetch(32'h80000000, 32'h12345678, 0, 0);
      for (int n = 0; n < 20 && !mem_arvalid; n++) @(negedge clk);
      mem_arready = 1'b1;
      @(negedge clk);
      mem_arready = 1'b0;
      check("pre_async_wait", {mem_rready, pc}, {1'b1, 32'h80000000});
      #2 rstn = 1'b0;
      #1 check("async_reset", {mem_arvalid, mem_rready, inst_valid, inst, pc},
               {1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      do_fetch(32'h80000000, 32'h00000413, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
